// File: rtl/vga_pkg.sv
// Shared pixel geometry and pixel record used by the drawing engines and the plot queue.
package vga_pkg;

  localparam int unsigned X_W      = 8;
  localparam int unsigned Y_W      = 7;
  localparam int unsigned COLOUR_W = 3;

  localparam logic [X_W-1:0] SCREEN_W = 8'd160;
  localparam logic [Y_W-1:0] SCREEN_H = 7'd120;

  typedef struct packed {
    logic [X_W-1:0]      x;
    logic [Y_W-1:0]      y;
    logic [COLOUR_W-1:0] colour;
  } pixel_t;

endpackage

// File: rtl/vga_plot_queue_if.sv
// Valid/ready pixel offer from a drawing engine into the plot queue.
interface vga_plot_queue_if;
  import vga_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [X_W-1:0]      in_x;
  logic [Y_W-1:0]      in_y;
  logic [COLOUR_W-1:0] in_colour;

  modport master (output in_valid, in_x, in_y, in_colour, input in_ready);
  modport slave  (input in_valid, in_x, in_y, in_colour, output in_ready);
endinterface

// File: rtl/vga_plot_queue_sync_fifo.sv
// Single-clock FIFO; full/empty come from the occupancy counter, pointers wrap naturally.
module sync_fifo #(
  parameter int unsigned WIDTH = 18,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == FULL_LVL);
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push && !rst) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/vga_plot_queue.sv
// Pixel plot queue feeding the VGA adapter one pixel per cycle.
// Define VGA_PLOT_QUEUE_CLIP_EN to silently drop off-screen pixels at the input.
module vga_plot_queue
  import vga_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  vga_plot_queue_if.slave         in_bus,
  input  logic                    out_en,
  output logic [X_W-1:0]          vga_x,
  output logic [Y_W-1:0]          vga_y,
  output logic [COLOUR_W-1:0]     vga_colour,
  output logic                    vga_plot,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    idle
);

  pixel_t wdata;
  pixel_t rdata;
  logic   full;
  logic   empty;
  logic   accept;
  logic   push;
  logic   pop;

  assign in_bus.in_ready = !full && !rst;
  assign accept          = in_bus.in_valid && in_bus.in_ready;
  assign wdata           = '{x: in_bus.in_x, y: in_bus.in_y, colour: in_bus.in_colour};

`ifdef VGA_PLOT_QUEUE_CLIP_EN
  // Off-screen pixels still complete the handshake but never reach storage.
  assign push = accept && (in_bus.in_x < SCREEN_W) && (in_bus.in_y < SCREEN_H);
`else
  assign push = accept;
`endif

  assign pop  = !empty && out_en;
  assign idle = empty && !vga_plot;

  sync_fifo #(
    .WIDTH ($bits(pixel_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (wdata),
    .rdata (rdata),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
    end else begin
      vga_plot <= pop;
      if (pop) begin
        vga_x      <= rdata.x;
        vga_y      <= rdata.y;
        vga_colour <= rdata.colour;
      end
    end
  end

endmodule

// File: tb/tb_vga_plot_queue.sv
// Directed table-driven bench for vga_plot_queue with DEPTH=4; honours VGA_PLOT_QUEUE_CLIP_EN.
module tb_vga_plot_queue;
  import vga_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       out_en;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic [2:0] level;
  logic       idle;

  int checks = 0;
  int errors = 0;

  vga_plot_queue_if bus ();

  vga_plot_queue #(.DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_bus     (bus.slave),
    .out_en     (out_en),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .level      (level),
    .idle       (idle)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       v;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    logic       en;
    logic       rdy;
    int         lvl;
    logic       plot;
    logic [7:0] ex;
    logic [6:0] ey;
    logic [2:0] ec;
    logic       eidle;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic v, input int x, input int y, input int c,
                     input logic en, input logic rdy, input int lvl, input logic plot,
                     input int ex, input int ey, input int ec, input logic eidle);
    vec_t t;
    t.rst = r; t.v = v; t.x = 8'(x); t.y = 7'(y); t.c = 3'(c); t.en = en;
    t.rdy = rdy; t.lvl = lvl; t.plot = plot;
    t.ex = 8'(ex); t.ey = 7'(ey); t.ec = 3'(ec); t.eidle = eidle;
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input int idx, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s vec %0d: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  initial begin
    int cnt;
    // rst v  x   y   c  en | rdy lvl plot ex  ey  ec idle
    add(1, 1,  1,  1, 1, 1,   0, 0, 0,  0,  0, 0, 1);
    add(1, 1,  1,  1, 1, 1,   0, 0, 0,  0,  0, 0, 1);
    add(0, 1, 10, 20, 5, 1,   1, 1, 0,  0,  0, 0, 0);
    add(0, 0,  0,  0, 0, 1,   1, 0, 1, 10, 20, 5, 0);
    add(0, 0,  0,  0, 0, 1,   1, 0, 0, 10, 20, 5, 1);
    add(0, 1,  1,  2, 1, 0,   1, 1, 0, 10, 20, 5, 0);
    add(0, 1,  3,  4, 2, 0,   1, 2, 0, 10, 20, 5, 0);
    add(0, 1,  5,  6, 3, 0,   1, 3, 0, 10, 20, 5, 0);
    add(0, 1,  7,  8, 4, 0,   1, 4, 0, 10, 20, 5, 0);
    add(0, 1,  9,  9, 6, 0,   0, 4, 0, 10, 20, 5, 0);
    add(0, 1, 11, 12, 7, 1,   0, 3, 1,  1,  2, 1, 0);
    add(0, 1, 11, 12, 7, 0,   1, 4, 0,  1,  2, 1, 0);
    add(0, 0,  0,  0, 0, 1,   0, 3, 1,  3,  4, 2, 0);
    add(0, 0,  0,  0, 0, 1,   1, 2, 1,  5,  6, 3, 0);
    add(0, 0,  0,  0, 0, 1,   1, 1, 1,  7,  8, 4, 0);
    add(0, 0,  0,  0, 0, 1,   1, 0, 1, 11, 12, 7, 0);
    add(0, 0,  0,  0, 0, 1,   1, 0, 0, 11, 12, 7, 1);
    add(0, 1, 20, 21, 1, 1,   1, 1, 0, 11, 12, 7, 0);
    add(0, 1, 22, 23, 2, 1,   1, 1, 1, 20, 21, 1, 0);
    add(0, 0,  0,  0, 0, 1,   1, 0, 1, 22, 23, 2, 0);
    add(0, 0,  0,  0, 0, 1,   1, 0, 0, 22, 23, 2, 1);
    add(0, 1, 30, 31, 1, 0,   1, 1, 0, 22, 23, 2, 0);
    add(0, 1, 32, 33, 2, 0,   1, 2, 0, 22, 23, 2, 0);
    add(0, 1, 34, 35, 3, 0,   1, 3, 0, 22, 23, 2, 0);
    add(0, 0,  0,  0, 0, 1,   1, 2, 1, 30, 31, 1, 0);
    add(1, 1, 40, 40, 4, 1,   0, 0, 0,  0,  0, 0, 1);
    add(0, 0,  0,  0, 0, 1,   1, 0, 0,  0,  0, 0, 1);
`ifdef VGA_PLOT_QUEUE_CLIP_EN
    add(0, 1, 160,   0, 1, 0, 1, 0, 0,   0,   0, 0, 1);
    add(0, 1,   0, 120, 2, 0, 1, 0, 0,   0,   0, 0, 1);
    add(0, 1, 159, 119, 3, 0, 1, 1, 0,   0,   0, 0, 0);
    add(0, 0,   0,   0, 0, 1, 1, 0, 1, 159, 119, 3, 0);
    add(0, 0,   0,   0, 0, 1, 1, 0, 0, 159, 119, 3, 1);
    add(0, 0,   0,   0, 0, 1, 1, 0, 0, 159, 119, 3, 1);
    add(0, 0,   0,   0, 0, 1, 1, 0, 0, 159, 119, 3, 1);
`else
    add(0, 1, 160,   0, 1, 0, 1, 1, 0,   0,   0, 0, 0);
    add(0, 1,   0, 120, 2, 0, 1, 2, 0,   0,   0, 0, 0);
    add(0, 1, 159, 119, 3, 0, 1, 3, 0,   0,   0, 0, 0);
    add(0, 0,   0,   0, 0, 1, 1, 2, 1, 160,   0, 1, 0);
    add(0, 0,   0,   0, 0, 1, 1, 1, 1,   0, 120, 2, 0);
    add(0, 0,   0,   0, 0, 1, 1, 0, 1, 159, 119, 3, 0);
    add(0, 0,   0,   0, 0, 1, 1, 0, 0, 159, 119, 3, 1);
`endif

    foreach (vecs[i]) begin
      rst           = vecs[i].rst;
      bus.in_valid  = vecs[i].v;
      bus.in_x      = vecs[i].x;
      bus.in_y      = vecs[i].y;
      bus.in_colour = vecs[i].c;
      out_en        = vecs[i].en;
      #1;
      chk("in_ready", i, int'(bus.in_ready), int'(vecs[i].rdy));
      @(posedge clk);
      #1;
      chk("level", i, int'(level), vecs[i].lvl);
      chk("vga_plot", i, int'(vga_plot), int'(vecs[i].plot));
      chk("vga_x", i, int'(vga_x), int'(vecs[i].ex));
      chk("vga_y", i, int'(vga_y), int'(vecs[i].ey));
      chk("vga_colour", i, int'(vga_colour), int'(vecs[i].ec));
      chk("idle", i, int'(idle), int'(vecs[i].eidle));
    end

    // Latency: push at edge k, strobe must appear after edge k+1 and last one cycle.
    bus.in_valid = 1'b1; bus.in_x = 8'd10; bus.in_y = 7'd20; bus.in_colour = 3'd5;
    out_en = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    cnt = 0;
    while (!vga_plot && cnt < 6) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    chk("latency_edges", 0, cnt, 1);
    chk("lat_x", 0, int'(vga_x), 10);
    chk("lat_y", 0, int'(vga_y), 20);
    chk("lat_colour", 0, int'(vga_colour), 5);
    @(posedge clk);
    #1;
    chk("strobe_width", 0, int'(vga_plot), 0);
    chk("idle_after", 0, int'(idle), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
